fetch_pair_ctrl: RTL and testbench
==================================

FETCH_PAIR_CTRL -- requirements
Module: fetch_pair_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter LAST_ADDR, default 8'd120: the highest byte address holding a valid instruction.
REQ-003 Parameter QDEPTH, default 4: the instruction queue depth in entries (fixed at 4 for this revision).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 inst_address  out  8  byte address driven to the instruction memory; it is a registered PC.
REQ-007 instruction1  in  32  word at inst_address, arriving combinationally from memory.
REQ-008 instruction2  in  32  word at inst_address+4, arriving combinationally from memory.
REQ-009 redirect  in  1  flush request carrying a new fetch target.
REQ-010 redirect_addr  in  8  new PC; bits [1:0] are forced to 0.
REQ-011 issue_take  in  2  number of slots consumed this cycle (0..2); the value 3 is treated as 2.
REQ-012 out_valid0, out_valid1  out  1 each  slot-valid flags; out_valid1 implies out_valid0.
REQ-013 out_inst0, out_inst1  out  32 each  queue head and head+1 instruction words.
REQ-014 out_pc0, out_pc1  out  8 each  byte address of each slot's instruction.
REQ-015 fetch_done  out  1  halted: PC is past LAST_ADDR.

Function
REQ-016 The queue SHALL be a 4-entry FIFO of {pc, inst} with a registered occupancy count of 0..4.
- Slots are driven from the queue registers only.
- There is no combinational path from instruction1/2 to the out_* ports.
REQ-017 Effective dequeue SHALL be min(issue_take, count); the two entries at the head retire in order.
REQ-018 Fetch-enable SHALL be: !halted && !redirect && count <= 2. The decision uses the registered count, not the post-dequeue count.
REQ-019 When fetch is enabled, the block SHALL:
- enqueue {pc, instruction1};
- enqueue {pc+4, instruction2} only if pc+4 <= LAST_ADDR;
- set pc <= pc+8.
REQ-020 If pc > LAST_ADDR, nothing SHALL be enqueued and halted SHALL set at the next edge; fetch_done = halted.
REQ-021 Enqueue and dequeue SHALL occur in the same cycle. New count = count + enq - deq, and it never exceeds 4.
REQ-022 Latency: a pair enqueued at edge N SHALL be visible on the slots after edge N. The first valid output is one cycle after reset is released.
REQ-023 Redirect SHALL win over enqueue and dequeue at the same edge:
- the queue is flushed (count 0, pointers 0);
- pc <= {redirect_addr[7:2], 2'b00};
- halted is cleared.
REQ-024 After a redirect, fetch SHALL resume at the next edge, and slots SHALL be valid two cycles after the redirect cycle.
REQ-025 Repeated redirects in consecutive cycles SHALL keep the queue empty; the last target wins.
REQ-026 The PC SHALL use 8-bit arithmetic. Wrap-around past 255 cannot occur, because halted sets first (LAST_ADDR <= 247).
REQ-027 When a slot is invalid, its inst and pc outputs SHALL be 0.

Reset
REQ-028 At an rst edge the block SHALL set:
- pc = 0, count = 0, read/write pointers = 0, halted = 0;
- all out_valid = 0, out_inst = 0, out_pc = 0;
- fetch_done = 0.
REQ-029 Reset SHALL dominate redirect and issue_take. Reset asserted mid-stream SHALL discard queued entries, with no partial retire.

Structure
REQ-030 A shared package fetch_pkg SHALL hold:
- ADDR_W = 8, INST_W = 32, QDEPTH = 4;
- the queue entry typedef {pc, inst}.
REQ-031 The queue SHALL be one sub-module, fetch_queue: a 2-write, 2-read FIFO with count output and flush input. The PC, halt and redirect logic stays in fetch_pair_ctrl.

Verification
REQ-032 The bench SHALL drive the block with the team's standard test program loaded in the instruction memory.
REQ-033 Scenario: reset release, issue_take = 2 every cycle.
- Required response, cycle 1: out_inst0 = 32'h00500093 (pc0 = 0) and out_inst1 = 32'hff200113 (pc1 = 4).
- Required response, cycle 2: 32'h00f00193 and 32'h01200213.
REQ-034 Scenario: issue_take = 0 for 5 cycles after reset.
- Required response: count saturates at 4 and inst_address holds at 16.
- out_pc0 stays 0 and out_pc1 stays 4.
REQ-035 Scenario: issue_take = 1 per cycle.
- Required response: out_pc0 steps 0, 4, 8, 12 on successive cycles.
- out_valid1 stays 1.
- Occupancy never exceeds 4.
REQ-036 Scenario: redirect = 1 with redirect_addr = 8'd41 while the queue holds 3 entries.
- Required response, next cycle: out_valid0 = 0.
- Required response, two cycles after: out_inst0 = 32'h002085b3 (pc0 = 40) and out_inst1 = 32'h00b18633 (pc1 = 44).
REQ-037 Scenario: redirect to 8'd116, then issue_take = 2.
- Required response: the pair at 116/120 is delivered, including 32'h02244eb3 at pc 120.
- pc then moves to 124, and fetch_done = 1 one cycle later with no further enqueue.
- A subsequent redirect to 0 clears fetch_done.
REQ-038 Scenario: rst asserted for 1 cycle while count = 3 and a redirect is pending.
- Required response, next cycle: all out_valid = 0, inst_address = 0 and fetch_done = 0.
- The redirect is ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared widths and queue entry type for the paired fetch front end.
// Imported by fetch_queue and fetch_pair_ctrl.
package fetch_pkg;

    localparam int ADDR_W = 8;
    localparam int INST_W = 32;
    localparam int QDEPTH = 4;
    localparam int PTR_W  = $clog2(QDEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } q_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Four-entry FIFO of {pc, inst} with two write ports and two read slots.
// Slots read only registered state; invalid slots are forced to zero.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [1:0]       enq_cnt,
    input  q_entry_t         enq0,
    input  q_entry_t         enq1,
    input  logic [1:0]       deq_req,
    output q_entry_t         head0,
    output q_entry_t         head1,
    output logic             valid0,
    output logic             valid1,
    output logic [CNT_W-1:0] count
);

    q_entry_t         mem [QDEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr1;
    logic [PTR_W-1:0] wr_ptr1;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       deq_sat;
    logic [1:0]       deq;

    assign rd_ptr1 = rd_ptr + PTR_W'(1);
    assign wr_ptr1 = wr_ptr + PTR_W'(1);

    // A take of 3 means 2; never retire more than is held.
    always_comb begin
        deq_sat = deq_req[1] ? 2'd2 : deq_req;
        deq     = deq_sat;
        if (cnt < CNT_W'(deq_sat)) begin
            deq = cnt[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(deq);
            wr_ptr <= wr_ptr + PTR_W'(enq_cnt);
            cnt    <= cnt + CNT_W'(enq_cnt) - CNT_W'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (enq_cnt != 2'd0) begin
                mem[wr_ptr] <= enq0;
            end
            if (enq_cnt == 2'd2) begin
                mem[wr_ptr1] <= enq1;
            end
        end
    end

    assign valid0 = (cnt != '0);
    assign valid1 = (cnt >= CNT_W'(2));
    assign head0  = valid0 ? mem[rd_ptr] : '0;
    assign head1  = valid1 ? mem[rd_ptr1] : '0;
    assign count  = cnt;

endmodule

// File: rtl/fetch_pair_ctrl.sv
// Paired instruction fetch: PC, halt and redirect control in front of
// a small queue that presents two issue slots per cycle.
module fetch_pair_ctrl
    import fetch_pkg::*;
#(
    parameter logic [7:0] LAST_ADDR = 8'd120,
    parameter int         QDEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] inst_address,
    input  logic [INST_W-1:0] instruction1,
    input  logic [INST_W-1:0] instruction2,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic [1:0]        issue_take,
    output logic              out_valid0,
    output logic              out_valid1,
    output logic [INST_W-1:0] out_inst0,
    output logic [INST_W-1:0] out_inst1,
    output logic [ADDR_W-1:0] out_pc0,
    output logic [ADDR_W-1:0] out_pc1,
    output logic              fetch_done
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] pc_plus8;
    logic              halted;
    logic              past_end;
    logic              fetch_en;
    logic [1:0]        enq_cnt;
    logic [CNT_W-1:0]  count;
    q_entry_t          enq0;
    q_entry_t          enq1;
    q_entry_t          head0;
    q_entry_t          head1;

    assign pc_plus4 = pc + ADDR_W'(4);
    assign pc_plus8 = pc + ADDR_W'(8);
    assign past_end = (pc > LAST_ADDR);

    // Gate on the registered count so a full pair always fits.
    assign fetch_en = !halted && !redirect && !past_end
                   && (int'(count) <= QDEPTH - 2);

    always_comb begin
        enq_cnt = 2'd0;
        if (fetch_en) begin
            enq_cnt = (pc_plus4 <= LAST_ADDR) ? 2'd2 : 2'd1;
        end
    end

    assign enq0 = '{pc: pc,       inst: instruction1};
    assign enq1 = '{pc: pc_plus4, inst: instruction2};

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= '0;
            halted <= 1'b0;
        end else if (redirect) begin
            pc     <= redirect_addr & ~ADDR_W'(3);
            halted <= 1'b0;
        end else begin
            if (past_end) begin
                halted <= 1'b1;
            end
            if (fetch_en) begin
                pc <= pc_plus8;
            end
        end
    end

    fetch_queue u_queue (
        .clk     (clk),
        .rst     (rst),
        .flush   (redirect),
        .enq_cnt (enq_cnt),
        .enq0    (enq0),
        .enq1    (enq1),
        .deq_req (issue_take),
        .head0   (head0),
        .head1   (head1),
        .valid0  (out_valid0),
        .valid1  (out_valid1),
        .count   (count)
    );

    assign inst_address = pc;
    assign out_inst0    = head0.inst;
    assign out_inst1    = head1.inst;
    assign out_pc0      = head0.pc;
    assign out_pc1      = head1.pc;
    assign fetch_done   = halted;

endmodule

// File: tb/tb_fetch_pair_ctrl.sv
// Directed and random stimulus for fetch_pair_ctrl against a queue-based
// reference model of the fetch rules.
module tb_fetch_pair_ctrl;

    localparam int LAST = 120;

    typedef struct {
        int          pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  inst_address;
    logic [31:0] instruction1;
    logic [31:0] instruction2;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_addr = 8'd0;
    logic [1:0]  issue_take = 2'd0;
    logic        out_valid0, out_valid1;
    logic [31:0] out_inst0, out_inst1;
    logic [7:0]  out_pc0, out_pc1;
    logic        fetch_done;

    logic [31:0] imem [64];
    logic [7:0]  addr2;

    ent_t q[$];
    int   mpc;
    bit   mhalt;
    int   nasrt = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    assign addr2        = inst_address + 8'd4;
    assign instruction1 = imem[inst_address[7:2]];
    assign instruction2 = imem[addr2[7:2]];

    fetch_pair_ctrl #(.LAST_ADDR(8'd120), .QDEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .inst_address  (inst_address),
        .instruction1  (instruction1),
        .instruction2  (instruction2),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .issue_take    (issue_take),
        .out_valid0    (out_valid0),
        .out_valid1    (out_valid1),
        .out_inst0     (out_inst0),
        .out_inst1     (out_inst1),
        .out_pc0       (out_pc0),
        .out_pc1       (out_pc1),
        .fetch_done    (fetch_done)
    );

    function automatic logic [31:0] word(input int a);
        logic [7:0] b;
        b = 8'(a);
        return imem[b[7:2]];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nasrt++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit rd,
                              input logic [7:0] ra, input int tk);
        int cnt, t, d;
        bit can;
        if (r) begin
            q.delete();
            mpc   = 0;
            mhalt = 0;
        end else if (rd) begin
            q.delete();
            mpc   = int'(ra) & 'hFC;
            mhalt = 0;
        end else begin
            cnt = q.size();
            t   = (tk == 3) ? 2 : tk;
            d   = (t < cnt) ? t : cnt;
            can = !mhalt && cnt <= 2;
            repeat (d) void'(q.pop_front());
            if (!mhalt && mpc > LAST) begin
                mhalt = 1;
            end else if (can) begin
                q.push_back('{mpc, word(mpc)});
                if (mpc + 4 <= LAST) q.push_back('{mpc + 4, word(mpc + 4)});
                mpc += 8;
            end
        end
    endtask

    task automatic check_model();
        bit v0, v1;
        v0 = q.size() >= 1;
        v1 = q.size() >= 2;
        chk("m_valid0", 32'(out_valid0), 32'(v0));
        chk("m_valid1", 32'(out_valid1), 32'(v1));
        chk("m_inst0", out_inst0, v0 ? q[0].inst : 32'd0);
        chk("m_inst1", out_inst1, v1 ? q[1].inst : 32'd0);
        chk("m_pc0", 32'(out_pc0), v0 ? 32'(q[0].pc) : 32'd0);
        chk("m_pc1", 32'(out_pc1), v1 ? 32'(q[1].pc) : 32'd0);
        chk("m_addr", 32'(inst_address), 32'(mpc[7:0]));
        chk("m_done", 32'(fetch_done), 32'(mhalt));
    endtask

    task automatic step(input bit r, input bit rd,
                        input logic [7:0] ra, input int tk);
        rst           = r;
        redirect      = rd;
        redirect_addr = ra;
        issue_take    = 2'(tk);
        @(posedge clk);
        model_edge(r, rd, ra, tk);
        #1;
        check_model();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = $urandom;
        imem[0]  = 32'h00500093;
        imem[1]  = 32'hff200113;
        imem[2]  = 32'h00f00193;
        imem[3]  = 32'h01200213;
        imem[10] = 32'h002085b3;
        imem[11] = 32'h00b18633;
        imem[30] = 32'h02244eb3;
        mpc   = 0;
        mhalt = 0;

        step(1, 0, 0, 0);
        step(1, 1, 8'd60, 2);
        chk("rst_valid0", 32'(out_valid0), 32'd0);
        chk("rst_addr", 32'(inst_address), 32'd0);
        chk("rst_done", 32'(fetch_done), 32'd0);
        chk("rst_inst0", out_inst0, 32'd0);

        step(0, 0, 0, 2);
        chk("c1_inst0", out_inst0, 32'h00500093);
        chk("c1_pc0", 32'(out_pc0), 32'd0);
        chk("c1_inst1", out_inst1, 32'hff200113);
        chk("c1_pc1", 32'(out_pc1), 32'd4);
        step(0, 0, 0, 2);
        chk("c2_inst0", out_inst0, 32'h00f00193);
        chk("c2_inst1", out_inst1, 32'h01200213);

        step(1, 0, 0, 0);
        repeat (5) step(0, 0, 0, 0);
        chk("sat_addr", 32'(inst_address), 32'd16);
        chk("sat_pc0", 32'(out_pc0), 32'd0);
        chk("sat_pc1", 32'(out_pc1), 32'd4);
        chk("sat_cnt", 32'(q.size()), 32'd4);

        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1);
            chk("t1_pc0", 32'(out_pc0), 32'(4 * i));
            chk("t1_valid1", 32'(out_valid1), 32'd1);
        end

        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 1, 8'd41, 0);
        chk("rd_valid0", 32'(out_valid0), 32'd0);
        step(0, 0, 0, 0);
        chk("rd_inst0", out_inst0, 32'h002085b3);
        chk("rd_pc0", 32'(out_pc0), 32'd40);
        chk("rd_inst1", out_inst1, 32'h00b18633);
        chk("rd_pc1", 32'(out_pc1), 32'd44);

        step(0, 1, 8'd116, 0);
        step(0, 0, 0, 2);
        chk("end_pc0", 32'(out_pc0), 32'd116);
        chk("end_inst1", out_inst1, 32'h02244eb3);
        chk("end_pc1", 32'(out_pc1), 32'd120);
        chk("end_addr", 32'(inst_address), 32'd124);
        chk("end_done0", 32'(fetch_done), 32'd0);
        step(0, 0, 0, 2);
        chk("end_done1", 32'(fetch_done), 32'd1);
        chk("end_empty", 32'(out_valid0), 32'd0);
        step(0, 0, 0, 2);
        chk("end_hold", 32'(out_valid0), 32'd0);
        step(0, 1, 8'd0, 0);
        chk("end_clr", 32'(fetch_done), 32'd0);

        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(1, 1, 8'd80, 2);
        chk("mid_valid0", 32'(out_valid0), 32'd0);
        chk("mid_addr", 32'(inst_address), 32'd0);
        chk("mid_done", 32'(fetch_done), 32'd0);
        step(0, 0, 0, 0);
        chk("mid_pc0", 32'(out_pc0), 32'd0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom % 64) == 0, ($urandom % 10) == 0,
                 8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nasrt, nfail);
        $finish;
    end

endmodule
